decode_issue_queue: RTL and testbench
=====================================

# decode_issue_queue

Buffers decoded instructions between the decode mux (third decode stage) and the issue stage. Single-clock FIFO with first-word-fall-through output, an almost-full stall back to the decode pipeline, a flush port for branch mispredicts, and sticky overflow detection. The decode stages have no backpressure path of their own, so this queue absorbs issue-side stalls.

## Interface
Parameters:
- depth, 8: entry count, power of two, 4..64
- stallThreshold, 6: occupancy at or above which stall_o asserts (< depth)
- addressWidth 64, opcodeSize 12, funcUnitCodeSize 3, instructionCounterWidth 64, instMinIdWidth 7, PidSize 20, TidSize 16, regSize 5, immWidth 64: field widths, same meaning as the decode stages

Ports:
- clock_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all entries
- enable_i  in  1  upstream entry valid this cycle
- opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i, pid_i, tid_i, op1_i..op4_i, imm_i  in  field widths  decoded instruction
- stall_o  out  1  request decode to stop issuing
- overflow_o  out  1  sticky: push arrived while full and no pop
- valid_o  out  1  head entry valid
- ready_i  in  1  issue stage accepts head this cycle
- opcode_o … imm_o  out  field widths  head entry fields
- count_o  out  log2(depth)+1  current occupancy

## Operation
- Storage: depth-entry array, 271-bit entries (all fields concatenated), read pointer, write pointer, occupancy count; pointers log2(depth) bits, wrap naturally modulo depth.
- push = enable_i & !flush_i & (count < depth | pop); pop = valid_o & ready_i & !flush_i.
- Simultaneous push and pop: both occur, count unchanged; legal at full and at empty+1.
- Push at empty with ready_i high: entry written, not visible until next cycle; pop not permitted same cycle.
- enable_i while full and no pop: entry dropped, overflow_o set to 1 and held until reset_i.
- flush_i: pointers and count cleared next edge; push/pop ignored that cycle; overflow_o unaffected.
- valid_o = (count != 0); output fields driven from array[rdPtr] (FWFT); fields undefined-but-stable when valid_o low.
- stall_o = (count >= stallThreshold), combinational from registered count.
- Reset (any time, including mid-push): count 0, pointers 0, overflow_o 0, valid_o 0, stall_o 0; array contents not reset.

## Timing
- Push at edge N → valid_o and head fields visible after edge N; earliest pop at edge N+1. Latency 1 cycle.
- Pop at edge N → next entry presented after edge N.
- stall_o follows count with zero extra delay; threshold leaves depth-stallThreshold slots for entries already in the decode pipeline.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- DECODE_QUEUE_STATS_EN defined: adds outputs pushCount_o (32 bit), stallCycles_o (32 bit, cycles with stall_o high), dropCount_o (16 bit, overflow drops); all saturate at max, reset to 0 by reset_i, not by flush_i.
- Undefined: these ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset, then push 3 entries (majID 1,2,3) with ready_i low → count_o 3, valid_o 1, majID_o 1; raise ready_i 3 cycles → majID_o 1,2,3 in order, then valid_o 0.
- Fill depth=8 with ready_i low → stall_o asserts at count 6; 9th push with no pop → overflow_o 1, count_o stays 8, head unchanged.
- Full queue, enable_i and ready_i both high for 20 cycles → no overflow, count_o 8 throughout, output majID sequence strictly increasing.
- 5 entries queued, pulse flush_i with enable_i high → count_o 0, valid_o 0 next cycle, pushed entry discarded.
- Assert reset_i asynchronously mid-cycle during a push with 4 entries held → all outputs reset immediately; after release, push majID 9 → head majID 9.
- With DECODE_QUEUE_STATS_EN: 10 pushes, 2 drops, stall high 4 cycles → pushCount_o 10, dropCount_o 2, stallCycles_o 4.

Source files
------------

// File: rtl/decode_issue_queue.sv
// Decode-to-issue FWFT queue: almost-full stall, flush, sticky overflow.
// Define DECODE_QUEUE_STATS_EN to add saturating push/stall/drop counters.
module decode_issue_queue #(
  parameter int depth                   = 8,
  parameter int stallThreshold          = 6,
  parameter int addressWidth            = 64,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int regSize                 = 5,
  parameter int immWidth                = 64
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               enable_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            address_i,
  input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
  input  logic [instructionCounterWidth-1:0] majID_i,
  input  logic [instMinIdWidth-1:0]          minID_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 pid_i,
  input  logic [TidSize-1:0]                 tid_i,
  input  logic [regSize-1:0]                 op1_i,
  input  logic [regSize-1:0]                 op2_i,
  input  logic [regSize-1:0]                 op3_i,
  input  logic [regSize-1:0]                 op4_i,
  input  logic [immWidth-1:0]                imm_i,
  output logic                               stall_o,
  output logic                               overflow_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            address_o,
  output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [instMinIdWidth-1:0]          minID_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic [regSize-1:0]                 op1_o,
  output logic [regSize-1:0]                 op2_o,
  output logic [regSize-1:0]                 op3_o,
  output logic [regSize-1:0]                 op4_o,
  output logic [immWidth-1:0]                imm_o,
  output logic [$clog2(depth):0]             count_o
`ifdef DECODE_QUEUE_STATS_EN
  ,
  output logic [31:0]                        pushCount_o,
  output logic [31:0]                        stallCycles_o,
  output logic [15:0]                        dropCount_o
`endif
);

  localparam int PTR_W   = $clog2(depth);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = opcodeSize + addressWidth + funcUnitCodeSize +
                           instructionCounterWidth + instMinIdWidth + 1 +
                           PidSize + TidSize + 4 * regSize + immWidth;

  typedef logic [ENTRY_W-1:0] entry_t;

  entry_t             mem_q [depth];
  entry_t             wr_entry;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full, push, pop, drop;

  assign wr_entry = {opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
                     pid_i, tid_i, op1_i, op2_i, op3_i, op4_i, imm_i};

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(depth));
  assign pop     = valid_o & ready_i & ~flush_i;
  // A pop frees the slot at full, so push and pop may both happen there.
  assign push    = enable_i & ~flush_i & (~full | pop);
  assign drop    = enable_i & ~flush_i & full & ~pop;

  // NOTE: every always_comb output takes its default first so no path can infer a latch.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the entry array has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign {opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
          pid_o, tid_o, op1_o, op2_o, op3_o, op4_o, imm_o} = mem_q[rd_ptr_q];

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign stall_o    = (count_q >= CNT_W'(stallThreshold));

`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0] push_count_q, push_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Statistics survive flush; only reset clears them. All saturate.
  always_comb begin
    push_count_d   = push_count_q;
    stall_cycles_d = stall_cycles_q;
    drop_count_d   = drop_count_q;
    if (push && push_count_q != '1)      push_count_d   = push_count_q + 1'b1;
    if (stall_o && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 1'b1;
    if (drop && drop_count_q != '1)      drop_count_d   = drop_count_q + 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      push_count_q   <= '0;
      stall_cycles_q <= '0;
      drop_count_q   <= '0;
    end else begin
      push_count_q   <= push_count_d;
      stall_cycles_q <= stall_cycles_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign pushCount_o   = push_count_q;
  assign stallCycles_o = stall_cycles_q;
  assign dropCount_o   = drop_count_q;
`endif

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_decode_issue_queue;

  localparam int DEPTH = 8;
  localparam int THR   = 6;

  logic        clock_i = 1'b0;
  logic        reset_i, flush_i, enable_i, ready_i;
  logic [11:0] opcode_i;   logic [63:0] address_i;  logic [2:0] funcUnitType_i;
  logic [63:0] majID_i;    logic [6:0]  minID_i;    logic       is64Bit_i;
  logic [19:0] pid_i;      logic [15:0] tid_i;
  logic [4:0]  op1_i, op2_i, op3_i, op4_i;          logic [63:0] imm_i;
  logic        stall_o, overflow_o, valid_o;
  logic [11:0] opcode_o;   logic [63:0] address_o;  logic [2:0] funcUnitType_o;
  logic [63:0] majID_o;    logic [6:0]  minID_o;    logic       is64Bit_o;
  logic [19:0] pid_o;      logic [15:0] tid_o;
  logic [4:0]  op1_o, op2_o, op3_o, op4_o;          logic [63:0] imm_o;
  logic [3:0]  count_o;
`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0] pushCount_o, stallCycles_o;
  logic [15:0] dropCount_o;
`endif

  decode_issue_queue #(.depth(DEPTH), .stallThreshold(THR)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
    .opcode_i(opcode_i), .address_i(address_i), .funcUnitType_i(funcUnitType_i),
    .majID_i(majID_i), .minID_i(minID_i), .is64Bit_i(is64Bit_i), .pid_i(pid_i),
    .tid_i(tid_i), .op1_i(op1_i), .op2_i(op2_i), .op3_i(op3_i), .op4_i(op4_i),
    .imm_i(imm_i), .stall_o(stall_o), .overflow_o(overflow_o), .valid_o(valid_o),
    .ready_i(ready_i), .opcode_o(opcode_o), .address_o(address_o),
    .funcUnitType_o(funcUnitType_o), .majID_o(majID_o), .minID_o(minID_o),
    .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o), .op1_o(op1_o),
    .op2_o(op2_o), .op3_o(op3_o), .op4_o(op4_o), .imm_o(imm_o), .count_o(count_o)
`ifdef DECODE_QUEUE_STATS_EN
    , .pushCount_o(pushCount_o), .stallCycles_o(stallCycles_o), .dropCount_o(dropCount_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;

  wire [270:0] head_w = {opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
                         pid_o, tid_o, op1_o, op2_o, op3_o, op4_o, imm_o};

  // Every field of an entry is derived from its majID so the whole head can be checked.
  function automatic logic [270:0] pack(input logic [63:0] m);
    return {m[11:0] ^ 12'h5a5, m[31:0], ~m[31:0], m[2:0] ^ 3'h5, m, m[6:0] + 7'd3,
            m[0], m[19:0] ^ 20'habcde, m[15:0] + 16'd1, m[4:0], m[9:5], m[14:10],
            ~m[4:0], ~m};
  endfunction

  task automatic check(input string name, input logic [270:0] act, input logic [270:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit fl, input bit en, input bit rd, input logic [63:0] maj);
    flush_i  = fl;
    enable_i = en;
    ready_i  = rd;
    {opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
     pid_i, tid_i, op1_i, op2_i, op3_i, op4_i, imm_i} = pack(maj);
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic do_cycle(input bit fl, input bit en, input bit rd, input logic [63:0] maj);
    drive(fl, en, rd, maj);
    @(posedge clock_i);
    #1;
  endtask

  // Behavioural reference: a plain queue of majIDs plus the sticky overflow bit.
  logic [63:0] mq[$];
  bit          m_ovf;

  task automatic model_step(input bit fl, input bit en, input bit rd, input logic [63:0] maj);
    int sz;
    bit pp;
    sz = mq.size();
    pp = (sz != 0) && rd && !fl;
    if (fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (en) begin
        if (sz < DEPTH || pp) mq.push_back(maj);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, 271'(count_o), 271'(mq.size()));
    check({tag, "_valid"}, 271'(valid_o), 271'(mq.size() != 0));
    check({tag, "_stall"}, 271'(stall_o), 271'(mq.size() >= THR));
    check({tag, "_ovf"},   271'(overflow_o), 271'(m_ovf));
    if (mq.size() != 0) check({tag, "_head"}, head_w, pack(mq[0]));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    reset_i = 1'b1;
    @(posedge clock_i);
    #2;
    reset_i = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  typedef struct {
    bit          fl, en, rd;
    logic [63:0] maj;
    int          cnt;
    bit          vld, stl, ovf;
    logic [63:0] head;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input bit fl, en, rd, input logic [63:0] maj, input int cnt,
                              input bit vld, stl, ovf, input logic [63:0] head);
    vec_t v;
    v.fl = fl; v.en = en; v.rd = rd; v.maj = maj; v.cnt = cnt;
    v.vld = vld; v.stl = stl; v.ovf = ovf; v.head = head;
    return v;
  endfunction

  initial begin
    logic [63:0] prev;

    //            fl en rd maj   cnt vld stl ovf head
    tbl[0]  = mk(0, 1, 0, 1,    1,  1,  0,  0,  1);
    tbl[1]  = mk(0, 1, 0, 2,    2,  1,  0,  0,  1);
    tbl[2]  = mk(0, 1, 0, 3,    3,  1,  0,  0,  1);
    tbl[3]  = mk(0, 0, 1, 0,    2,  1,  0,  0,  2);
    tbl[4]  = mk(0, 0, 1, 0,    1,  1,  0,  0,  3);
    tbl[5]  = mk(0, 0, 1, 0,    0,  0,  0,  0,  0);
    for (int i = 0; i < 8; i++)
      tbl[6+i] = mk(0, 1, 0, 64'(10 + i), i + 1, 1, (i + 1) >= 6, 0, 10);
    tbl[14] = mk(0, 1, 0, 18,   8,  1,  1,  1,  10);  // push at full, no pop: dropped
    tbl[15] = mk(0, 1, 1, 19,   8,  1,  1,  1,  11);  // push+pop at full
    tbl[16] = mk(1, 1, 1, 20,   0,  0,  0,  1,  0);   // flush discards push too
    tbl[17] = mk(0, 1, 1, 21,   1,  1,  0,  1,  21);  // push at empty, no same-cycle pop
    tbl[18] = mk(0, 0, 1, 0,    0,  0,  0,  1,  0);

    do_reset();
    check("rst_count", 271'(count_o), 271'(0));
    check("rst_valid", 271'(valid_o), 271'(0));
    check("rst_stall", 271'(stall_o), 271'(0));
    check("rst_ovf",   271'(overflow_o), 271'(0));

    for (int i = 0; i < 19; i++) begin
      do_cycle(tbl[i].fl, tbl[i].en, tbl[i].rd, tbl[i].maj);
      check($sformatf("vec%0d_count", i), 271'(count_o), 271'(tbl[i].cnt));
      check($sformatf("vec%0d_valid", i), 271'(valid_o), 271'(tbl[i].vld));
      check($sformatf("vec%0d_stall", i), 271'(stall_o), 271'(tbl[i].stl));
      check($sformatf("vec%0d_ovf", i),   271'(overflow_o), 271'(tbl[i].ovf));
      if (tbl[i].vld) check($sformatf("vec%0d_head", i), head_w, pack(tbl[i].head));
    end

    // Asynchronous reset mid-cycle during a push, with 4 entries held and overflow set.
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 64'(30 + i));
    check("pre_arst_count", 271'(count_o), 271'(4));
    drive(0, 1, 0, 64'd40);
    #3;
    reset_i = 1'b1;
    #1;
    check("arst_count", 271'(count_o), 271'(0));
    check("arst_valid", 271'(valid_o), 271'(0));
    check("arst_stall", 271'(stall_o), 271'(0));
    check("arst_ovf",   271'(overflow_o), 271'(0));
    drive(0, 0, 0, 64'd0);
    @(posedge clock_i);
    #2;
    reset_i = 1'b0;
    do_cycle(0, 1, 0, 64'd9);
    check("post_arst_count", 271'(count_o), 271'(1));
    check("post_arst_head",  head_w, pack(64'd9));

    // Fill to full, then sustain simultaneous push and pop at full.
    for (int i = 0; i < 7; i++) do_cycle(0, 1, 0, 64'(10 + i));
    check("full_count", 271'(count_o), 271'(8));
    prev = 64'd9;
    for (int i = 0; i < 20; i++) begin
      do_cycle(0, 1, 1, 64'(100 + i));
      check($sformatf("sust%0d_count", i), 271'(count_o), 271'(8));
      check($sformatf("sust%0d_ovf", i),   271'(overflow_o), 271'(0));
      check($sformatf("sust%0d_incr", i),  271'(majID_o > prev), 271'(1));
      prev = majID_o;
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit fl, en, rd;
      logic [63:0] maj;
      fl  = ($urandom_range(31) == 0);
      en  = ($urandom_range(9) < 6);
      rd  = (i % 128 < 64) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 7);
      maj = {32'($urandom), 32'(i)};
      model_step(fl, en, rd, maj);
      do_cycle(fl, en, rd, maj);
      check_model($sformatf("rnd%0d", i));
    end

`ifdef DECODE_QUEUE_STATS_EN
    // 10 pushes, 2 drops, stall high on exactly 4 edges.
    do_reset();
    do_cycle(0, 1, 1, 64'd1);
    do_cycle(0, 1, 1, 64'd2);
    do_cycle(0, 0, 1, 64'd0);
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0, 64'(50 + i));
    do_cycle(0, 1, 0, 64'd60);
    do_cycle(0, 1, 0, 64'd61);
    check("stats_push",  271'(pushCount_o),   271'(10));
    check("stats_drop",  271'(dropCount_o),   271'(2));
    check("stats_stall", 271'(stallCycles_o), 271'(4));
    do_cycle(1, 0, 0, 64'd0);
    check("stats_push_after_flush", 271'(pushCount_o), 271'(10));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
